// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one 4-function ALU between two requesters.
// One op in flight: IDLE grants a request, EXEC drives the ALU for an
// op-dependent number of cycles, RESP holds the tagged result until consumed.
module alu_arbiter #(
    parameter int WIDTH    = 8,
    parameter int BASE_LAT = 1,
    parameter int MUL_LAT  = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic [1:0]         req0_op,
    input  logic [WIDTH-1:0]   req0_a,
    input  logic [WIDTH-1:0]   req0_b,
    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic [1:0]         req1_op,
    input  logic [WIDTH-1:0]   req1_a,
    input  logic [WIDTH-1:0]   req1_b,
    output logic [3:0]         alu_control,
    output logic [WIDTH-1:0]   alu_a,
    output logic [WIDTH-1:0]   alu_b,
    input  logic [2*WIDTH-1:0] alu_result,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic               rsp_id,
    output logic [2*WIDTH-1:0] rsp_data
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    localparam int MAXL = (MUL_LAT > BASE_LAT) ? MUL_LAT : BASE_LAT;
    localparam int CW   = $clog2(MAXL + 1);
    localparam logic [1:0] OP_MUL = 2'd2;

    state_t            state;
    logic              ptr;      // requester favoured when both are valid
    logic [CW-1:0]     cnt;      // EXEC cycles remaining, including the current one
    logic              id_q;
    logic              grant1;
    logic              accept;
    logic [1:0]        op_sel;
    logic [WIDTH-1:0]  a_sel;
    logic [WIDTH-1:0]  b_sel;

    // Grant selection and payload mux; ready only for the winner, only in IDLE
    always_comb begin
        grant1     = req1_valid && (!req0_valid || ptr);
        req0_ready = (state == IDLE) && !reset && req0_valid && !grant1;
        req1_ready = (state == IDLE) && !reset && grant1;
        accept     = req0_ready || req1_ready;
        op_sel     = grant1 ? req1_op : req0_op;
        a_sel      = grant1 ? req1_a  : req0_a;
        b_sel      = grant1 ? req1_b  : req0_b;
    end

    // Sequencer: latch on accept, count down EXEC, hold the response until taken
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            ptr         <= 1'b0;
            cnt         <= '0;
            id_q        <= 1'b0;
            alu_control <= 4'b0000;
            alu_a       <= '0;
            alu_b       <= '0;
            rsp_valid   <= 1'b0;
            rsp_id      <= 1'b0;
            rsp_data    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        id_q        <= grant1;
                        alu_a       <= a_sel;
                        alu_b       <= b_sel;
                        alu_control <= 4'b0001 << op_sel;
                        cnt         <= (op_sel == OP_MUL) ? CW'(MUL_LAT) : CW'(BASE_LAT);
                        state       <= EXEC;
                    end
                end
                EXEC: begin
                    // alu_result is valid at the end of the final EXEC cycle
                    if (cnt == CW'(1)) begin
                        rsp_data    <= alu_result;
                        rsp_id      <= id_q;
                        rsp_valid   <= 1'b1;
                        alu_control <= 4'b0000;
                        state       <= RESP;
                    end
                    cnt <= cnt - 1'b1;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        ptr       <= ~id_q;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: behavioural ALU, scoreboard of expected responses
// pushed at each accepted request and popped at each consumed response.
module tb_alu_arbiter;

    localparam int W = 8;

    logic           clk = 1'b0;
    logic           reset;
    logic           req0_valid, req1_valid;
    logic           req0_ready, req1_ready;
    logic [1:0]     req0_op, req1_op;
    logic [W-1:0]   req0_a, req0_b, req1_a, req1_b;
    logic [3:0]     alu_control;
    logic [W-1:0]   alu_a, alu_b;
    logic [2*W-1:0] alu_result;
    logic           rsp_valid, rsp_ready, rsp_id;
    logic [2*W-1:0] rsp_data;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct packed {
        logic           id;
        logic [2*W-1:0] data;
    } exp_t;
    exp_t sb[$];

    alu_arbiter #(.WIDTH(W), .BASE_LAT(1), .MUL_LAT(3)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .alu_control(alu_control), .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data)
    );

    always #5 clk = ~clk;

    function automatic logic [2*W-1:0] alu_f(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] ea, eb;
        ea = {{W{1'b0}}, a};
        eb = {{W{1'b0}}, b};
        case (op)
            2'd0:    return ea + eb;
            2'd1:    return ea - eb;
            2'd2:    return ea * eb;
            default: return ea % 16'd3;
        endcase
    endfunction

    // Behavioural ALU driven by the one-hot control
    always_comb begin
        case (alu_control)
            4'b0001: alu_result = alu_f(2'd0, alu_a, alu_b);
            4'b0010: alu_result = alu_f(2'd1, alu_a, alu_b);
            4'b0100: alu_result = alu_f(2'd2, alu_a, alu_b);
            4'b1000: alu_result = alu_f(2'd3, alu_a, alu_b);
            default: alu_result = '0;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // From a negedge: wait (bounded) until rsp_valid is high
    task automatic wait_rsp();
        int k = 0;
        while (!rsp_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!rsp_valid) chk("rsp_timeout", 32'd0, 32'd1);
    endtask

    // Single-requester op: checks grant and the one-hot control, then drains
    task automatic run_op(input logic id, input logic [1:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [3:0] ctl);
        tick();
        if (id) begin req1_op = op; req1_a = a; req1_b = b; req1_valid = 1'b1; end
        else    begin req0_op = op; req0_a = a; req0_b = b; req0_valid = 1'b1; end
        @(negedge clk);
        chk("op_ready", id ? req1_ready : req0_ready, 32'd1);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
        chk("op_ctl", alu_control, ctl);
        wait_rsp();
        tick();
    endtask

    // Scoreboard and always-on invariants
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            sb.delete();
        end else begin
            if (req0_ready || req1_ready) chk("one_ready", req0_ready & req1_ready, 32'd0);
            if (req0_valid && req0_ready) sb.push_back({1'b0, alu_f(req0_op, req0_a, req0_b)});
            if (req1_valid && req1_ready) sb.push_back({1'b1, alu_f(req1_op, req1_a, req1_b)});
            if (rsp_valid) chk("resp_ctl_idle", alu_control, 32'd0);
            if (rsp_valid && rsp_ready) begin
                if (sb.size() == 0) chk("sb_unexpected", 32'd1, 32'd0);
                else begin
                    e = sb.pop_front();
                    chk("sb_id", rsp_id, e.id);
                    chk("sb_data", rsp_data, e.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, nmul, grants, expid, guard;
        logic g0, g1;
        reset = 1'b1; rsp_ready = 1'b1;
        req0_valid = 1'b1; req0_op = 2'd0; req0_a = 8'd0; req0_b = 8'd0;
        req1_valid = 1'b0; req1_op = 2'd0; req1_a = 8'd0; req1_b = 8'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready0", req0_ready, 32'd0);
        chk("rst_ctl", alu_control, 32'd0);
        chk("rst_a", alu_a, 32'd0);
        chk("rst_b", alu_b, 32'd0);
        chk("rst_rsp_valid", rsp_valid, 32'd0);
        chk("rst_rsp_id", rsp_id, 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        req0_valid = 1'b0;
        tick();
        reset = 1'b0;

        // ADD 5+3 from req0, BASE_LAT=1
        tick();
        req0_op = 2'd0; req0_a = 8'd5; req0_b = 8'd3; req0_valid = 1'b1;
        @(negedge clk);
        chk("t1_ready0", req0_ready, 32'd1);
        chk("t1_ready1", req1_ready, 32'd0);
        tick();
        req0_valid = 1'b0;
        @(negedge clk);
        chk("t1_ctl", alu_control, 32'h1);
        chk("t1_alu_a", alu_a, 32'd5);
        chk("t1_alu_b", alu_b, 32'd3);
        chk("t1_early_rsp", rsp_valid, 32'd0);
        tick();
        @(negedge clk);
        chk("t1_rsp_valid", rsp_valid, 32'd1);
        chk("t1_rsp_id", rsp_id, 32'd0);
        chk("t1_rsp_data", rsp_data, 32'd8);
        tick();
        @(negedge clk);
        chk("t1_rsp_drop", rsp_valid, 32'd0);

        // MUL 12*11 from req1, MUL_LAT=3
        tick();
        req1_op = 2'd2; req1_a = 8'd12; req1_b = 8'd11; req1_valid = 1'b1;
        @(negedge clk);
        chk("t2_ready1", req1_ready, 32'd1);
        chk("t2_ready0", req0_ready, 32'd0);
        tick();
        req1_valid = 1'b0;
        nmul = 0;
        cyc = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            cyc = i;
            if (rsp_valid) break;
            if (alu_control == 4'b0100) nmul++;
            @(posedge clk);
        end
        chk("t2_mul_cycles", nmul, 32'd3);
        chk("t2_latency", cyc, 32'd3);
        chk("t2_rsp_id", rsp_id, 32'd1);
        chk("t2_rsp_data", rsp_data, 32'd132);
        tick();

        // Only req1 valid while pointer favours req0
        run_op(1'b1, 2'd1, 8'd9, 8'd4, 4'b0010);
        run_op(1'b1, 2'd3, 8'd100, 8'd7, 4'b1000);

        // Both requesters valid for four ops: alternate 0,1,0,1
        req0_op = 2'd0; req0_a = 8'd10; req0_b = 8'd1;
        req1_op = 2'd1; req1_a = 8'd50; req1_b = 8'd2;
        req0_valid = 1'b1; req1_valid = 1'b1;
        grants = 0; expid = 0; guard = 0;
        while (grants < 4 && guard < 100) begin
            @(negedge clk);
            g0 = req0_ready; g1 = req1_ready;
            if (g0 || g1) begin
                chk("t3_order", g1, expid);
                expid ^= 1;
                grants++;
            end
            guard++;
            tick();
            if (grants == 4) begin req0_valid = 1'b0; req1_valid = 1'b0; end
            else begin
                if (g0) req0_a = req0_a + 8'd1;
                if (g1) req1_a = req1_a + 8'd3;
            end
        end
        chk("t3_grants", grants, 32'd4);
        @(negedge clk);
        wait_rsp();
        tick();

        // Response stall: 5 cycles with rsp_ready low
        rsp_ready = 1'b0;
        req0_op = 2'd0; req0_a = 8'd20; req0_b = 8'd30; req0_valid = 1'b1;
        @(negedge clk);
        chk("t4_ready0", req0_ready, 32'd1);
        tick();
        req0_valid = 1'b0;
        req1_op = 2'd0; req1_a = 8'd2; req1_b = 8'd2; req1_valid = 1'b1;
        @(negedge clk);
        wait_rsp();
        for (int i = 0; i < 5; i++) begin
            chk("t4_hold_valid", rsp_valid, 32'd1);
            chk("t4_hold_data", rsp_data, 32'd50);
            chk("t4_hold_id", rsp_id, 32'd0);
            chk("t4_no_grant", req1_ready | req0_ready, 32'd0);
            chk("t4_ctl", alu_control, 32'd0);
            if (i < 4) @(negedge clk);
        end
        tick();
        rsp_ready = 1'b1;
        tick();
        @(negedge clk);
        chk("t4_next_grant", req1_ready, 32'd1);
        tick();
        req1_valid = 1'b0;
        @(negedge clk);
        wait_rsp();
        tick();

        // Move pointer to req1, then reset in the 2nd MUL EXEC cycle
        run_op(1'b0, 2'd0, 8'd1, 8'd1, 4'b0001);
        tick();
        req0_op = 2'd2; req0_a = 8'd7; req0_b = 8'd9; req0_valid = 1'b1;
        @(negedge clk);
        chk("t6_ready0", req0_ready, 32'd1);
        tick();
        req0_valid = 1'b0;
        @(negedge clk);
        chk("t6_exec1_ctl", alu_control, 32'h4);
        tick();
        reset = 1'b1;
        @(negedge clk);
        chk("t6_rst_ctl", alu_control, 32'd0);
        chk("t6_rst_a", alu_a, 32'd0);
        chk("t6_rst_b", alu_b, 32'd0);
        chk("t6_rst_valid", rsp_valid, 32'd0);
        chk("t6_rst_data", rsp_data, 32'd0);
        tick();
        reset = 1'b0;
        req0_op = 2'd0; req0_a = 8'd3; req0_b = 8'd4;
        req1_op = 2'd0; req1_a = 8'd6; req1_b = 8'd6;
        req0_valid = 1'b1; req1_valid = 1'b1;
        @(negedge clk);
        chk("t6_ptr_ready0", req0_ready, 32'd1);
        chk("t6_ptr_ready1", req1_ready, 32'd0);
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
        wait_rsp();
        chk("t6_rsp_id", rsp_id, 32'd0);
        chk("t6_rsp_data", rsp_data, 32'd7);
        tick();
        repeat (3) tick();
        chk("sb_drain", sb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
